// File: rtl/pc_ins_sel_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding and
// default geometry of the instruction bus.
package pc_ins_sel_pkg;

   localparam int DEF_WIDTH = 9;
   localparam int DEF_DEPTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/pc_ins_sel_mux_n_1.sv
// Combinational WIDTH-bit DEPTH:1 word selector on a binary select.
// A select value that names no word yields all zeros.
module mux_n_1 #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   parameter int SW    = $clog2(DEPTH)
) (
   input  logic [DEPTH*WIDTH-1:0] din,
   input  logic [SW-1:0]          sel,
   output logic [WIDTH-1:0]       dout
);

   localparam logic [SW:0] DEPTH_EXT = (SW+1)'(DEPTH);

   logic [WIDTH-1:0] words [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_split
         assign words[gi] = din[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Pick the addressed word, zero when the select is past the last word.
   always_comb begin
      dout = '0;
      if ({1'b0, sel} < DEPTH_EXT) begin
         dout = words[sel];
      end
   end

endmodule

// File: rtl/pc_ins_sel.sv
// Program-counter driven instruction selector. In RUN the word addressed by
// pc is registered into ins every cycle while pc advances (halt > jump >
// increment). IDLE and HALTED hold ins/ins_pc/pc and ignore jumps.
module pc_ins_sel
   import pc_ins_sel_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DEPTH*WIDTH-1:0] ins_bus,
   input  logic                   start,
   input  logic                   halt,
   input  logic                   jump,
   input  logic [AW-1:0]          jump_addr,
   output logic [AW-1:0]          pc,
   output logic [WIDTH-1:0]       ins,
   output logic [AW-1:0]          ins_pc,
   output logic                   ins_valid,
   output logic                   running,
   output logic                   wrap,
   output logic                   err
);

   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_PC   = AW'(DEPTH-1);

   state_t           state_reg, state_next;
   logic [AW-1:0]    pc_reg, pc_next;
   logic [WIDTH-1:0] ins_reg, ins_next;
   logic [AW-1:0]    ins_pc_reg, ins_pc_next;
   logic             valid_reg, valid_next;
   logic             wrap_reg, wrap_next;
   logic             err_reg, err_next;
   logic [WIDTH-1:0] sel_word;

   mux_n_1 #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .SW    (AW)
   ) u_mux (
      .din  (ins_bus),
      .sel  (pc_reg),
      .dout (sel_word)
   );

   // Next-state and datapath decisions; pulses default low, data holds.
   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ins_next    = ins_reg;
      ins_pc_next = ins_pc_reg;
      valid_next  = 1'b0;
      wrap_next   = 1'b0;
      err_next    = 1'b0;
      case (state_reg)
         ST_IDLE, ST_HALTED: begin
            // start only wins when halt is not asserted alongside it
            if (start && !halt) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_next = ST_HALTED;
            end else begin
               ins_next    = sel_word;
               ins_pc_next = pc_reg;
               valid_next  = 1'b1;
               if (jump) begin
                  if ({1'b0, jump_addr} < DEPTH_EXT) begin
                     pc_next = jump_addr;
                  end else begin
                     pc_next  = '0;
                     err_next = 1'b1;
                  end
               end else if (pc_reg == LAST_PC) begin
                  pc_next   = '0;
                  wrap_next = 1'b1;
               end else begin
                  pc_next = pc_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         pc_reg     <= '0;
         ins_reg    <= '0;
         ins_pc_reg <= '0;
         valid_reg  <= 1'b0;
         wrap_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         ins_reg    <= ins_next;
         ins_pc_reg <= ins_pc_next;
         valid_reg  <= valid_next;
         wrap_reg   <= wrap_next;
         err_reg    <= err_next;
      end
   end

   assign pc        = pc_reg;
   assign ins       = ins_reg;
   assign ins_pc    = ins_pc_reg;
   assign ins_valid = valid_reg;
   assign wrap      = wrap_reg;
   assign err       = err_reg;
   assign running   = (state_reg == ST_RUN);

endmodule

// File: tb/tb_pc_ins_sel.sv
// Bench for pc_ins_sel: a default (16-word) and a 10-word instance share the
// control stimulus; each is compared every cycle against a behavioural model,
// and directed scenarios add literal expectations on top.
module tb_pc_ins_sel;

   localparam int W = 9;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALTED = 2;

   typedef struct {
      int state;
      int pc;
      int ins;
      int ins_pc;
      int valid;
      int wrap;
      int err;
   } model_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            start, halt, jump;
   logic [3:0]      jump_addr;
   logic [16*W-1:0] ins_bus16;
   logic [10*W-1:0] ins_bus10;

   logic [3:0]   pc16, ins_pc16, pc10, ins_pc10;
   logic [W-1:0] ins16, ins10;
   logic         valid16, running16, wrap16, err16;
   logic         valid10, running10, wrap10, err10;

   int checks = 0;
   int errors = 0;
   bit model_ok = 1'b0;
   model_t m16, m10;

   assign ins_bus10 = ins_bus16[10*W-1:0];

   always #5 clk = ~clk;

   pc_ins_sel dut16 (
      .clk(clk), .reset(reset), .ins_bus(ins_bus16), .start(start), .halt(halt),
      .jump(jump), .jump_addr(jump_addr), .pc(pc16), .ins(ins16), .ins_pc(ins_pc16),
      .ins_valid(valid16), .running(running16), .wrap(wrap16), .err(err16)
   );

   pc_ins_sel #(.WIDTH(W), .DEPTH(10)) dut10 (
      .clk(clk), .reset(reset), .ins_bus(ins_bus10), .start(start), .halt(halt),
      .jump(jump), .jump_addr(jump_addr), .pc(pc10), .ins(ins10), .ins_pc(ins_pc10),
      .ins_valid(valid10), .running(running10), .wrap(wrap10), .err(err10)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Bus word k carries k+1.
   function automatic int word_of(input int k);
      return k + 1;
   endfunction

   // One clock of the sequencer described as plain arithmetic.
   function automatic model_t step(input model_t m, input int depth, input bit rst,
                                   input bit st, input bit hl, input bit jp, input int ja);
      model_t n;
      n = m;
      n.valid = 0;
      n.wrap  = 0;
      n.err   = 0;
      if (rst) begin
         n = '{M_IDLE, 0, 0, 0, 0, 0, 0};
      end else if (m.state != M_RUN) begin
         if (st && !hl) n.state = M_RUN;
      end else if (hl) begin
         n.state = M_HALTED;
      end else begin
         n.ins    = word_of(m.pc);
         n.ins_pc = m.pc;
         n.valid  = 1;
         if (jp) begin
            if (ja < depth) n.pc = ja;
            else begin
               n.pc  = 0;
               n.err = 1;
            end
         end else begin
            n.pc   = (m.pc + 1) % depth;
            n.wrap = (m.pc == depth - 1) ? 1 : 0;
         end
      end
      return n;
   endfunction

   // Advance both models on the same edge the DUTs sample.
   always @(posedge clk) begin
      m16 <= step(m16, 16, reset, start, halt, jump, int'(jump_addr));
      m10 <= step(m10, 10, reset, start, halt, jump, int'(jump_addr));
      model_ok <= 1'b1;
   end

   // Every-cycle comparison of both instances against their models.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("pc16",      int'(pc16),      m16.pc);
         chk("ins16",     int'(ins16),     m16.ins);
         chk("ins_pc16",  int'(ins_pc16),  m16.ins_pc);
         chk("valid16",   int'(valid16),   m16.valid);
         chk("running16", int'(running16), (m16.state == M_RUN) ? 1 : 0);
         chk("wrap16",    int'(wrap16),    m16.wrap);
         chk("err16",     int'(err16),     m16.err);
         chk("pc10",      int'(pc10),      m10.pc);
         chk("ins10",     int'(ins10),     m10.ins);
         chk("ins_pc10",  int'(ins_pc10),  m10.ins_pc);
         chk("valid10",   int'(valid10),   m10.valid);
         chk("running10", int'(running10), (m10.state == M_RUN) ? 1 : 0);
         chk("wrap10",    int'(wrap10),    m10.wrap);
         chk("err10",     int'(err10),     m10.err);
         if (valid16)
            $display("fetch16 ins_pc=%0d ins=%0d pc=%0d wrap=%0b", ins_pc16, ins16, pc16, wrap16);
      end
   end

   // Wait (bounded) until the 16-word model reaches a given pc.
   task automatic run_to(input int target);
      int n;
      n = 0;
      while (m16.pc != target && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("run_to_pc", m16.pc, target);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; halt = 1'b0; jump = 1'b0; jump_addr = '0;
      for (int k = 0; k < 16; k++) ins_bus16[k*W +: W] = W'(k + 1);
      repeat (3) @(negedge clk);

      // Reset values
      $display("scenario: reset state");
      chk("rst_pc", int'(pc16), 0);
      chk("rst_ins", int'(ins16), 0);
      chk("rst_valid", int'(valid16), 0);
      chk("rst_running", int'(running16), 0);

      // Sequential lap with wrap
      $display("scenario: full lap");
      reset = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_running", int'(running16), 1);
      chk("start_no_fetch", int'(valid16), 0);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         chk("lap_ins", int'(ins16), ((k - 1) % 16) + 1);
         chk("lap_ins_pc", int'(ins_pc16), (k - 1) % 16);
         chk("lap_wrap", int'(wrap16), (k == 16) ? 1 : 0);
      end

      // In-range jump 5 -> 12
      $display("scenario: jump 5->12");
      run_to(5);
      chk("jmp_pc", int'(pc16), 5);
      jump = 1'b1; jump_addr = 4'd12;
      @(negedge clk);
      jump = 1'b0;
      chk("jmp_f0", int'(ins_pc16), 5);
      chk("jmp_err", int'(err16), 0);
      @(negedge clk);
      chk("jmp_f1", int'(ins_pc16), 12);
      @(negedge clk);
      chk("jmp_f2", int'(ins_pc16), 13);
      chk("jmp_wrap", int'(wrap16), 0);

      // Out-of-range jump on the 10-word instance
      $display("scenario: out-of-range jump");
      jump = 1'b1; jump_addr = 4'd11;
      @(negedge clk);
      jump = 1'b0;
      chk("oor_err", int'(err10), 1);
      chk("oor_pc", int'(pc10), 0);
      @(negedge clk);
      chk("oor_err_clear", int'(err10), 0);
      chk("oor_fetch", int'(ins_pc10), 0);
      chk("oor_valid", int'(valid10), 1);

      // Halt at 7, jump ignored, start+halt stays halted, resume
      $display("scenario: halt and resume");
      run_to(7);
      halt = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      chk("halt_running", int'(running16), 0);
      chk("halt_pc", int'(pc16), 7);
      chk("halt_ins", int'(ins16), 7);
      jump = 1'b1; jump_addr = 4'd2;
      @(negedge clk);
      jump = 1'b0;
      chk("halt_jump_ignored", int'(pc16), 7);
      chk("halt_valid", int'(valid16), 0);
      start = 1'b1; halt = 1'b1;
      @(negedge clk);
      start = 1'b0; halt = 1'b0;
      chk("halt_both_stay", int'(running16), 0);
      chk("halt_ins_hold", int'(ins16), 7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("resume_running", int'(running16), 1);
      chk("resume_no_fetch", int'(valid16), 0);
      @(negedge clk);
      chk("resume_ins_pc", int'(ins_pc16), 7);
      chk("resume_ins", int'(ins16), 8);

      // halt, jump and start together in RUN
      $display("scenario: halt+jump+start");
      run_to(3);
      halt = 1'b1; jump = 1'b1; start = 1'b1; jump_addr = 4'd9;
      @(negedge clk);
      halt = 1'b0; jump = 1'b0; start = 1'b0;
      chk("hjs_running", int'(running16), 0);
      chk("hjs_pc", int'(pc16), 3);
      chk("hjs_err16", int'(err16), 0);
      chk("hjs_err10", int'(err10), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Reset mid-RUN
      $display("scenario: reset mid-run");
      run_to(9);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_pc", int'(pc16), 0);
      chk("mrst_ins", int'(ins16), 0);
      chk("mrst_ins_pc", int'(ins_pc16), 0);
      chk("mrst_valid", int'(valid16), 0);
      chk("mrst_running", int'(running16), 0);
      start = 1'b1; halt = 1'b1;
      @(negedge clk);
      start = 1'b0; halt = 1'b0;
      chk("idle_both_stay", int'(running16), 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("mrst_refetch_pc", int'(ins_pc16), 0);
      chk("mrst_refetch_ins", int'(ins16), 1);
      chk("mrst_refetch_valid", int'(valid16), 1);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_ins_sel.md
PC_INS_SEL -- requirements
Module: pc_ins_sel

Interface
REQ-001 Parameter WIDTH, default 9, SHALL be the instruction word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, SHALL be the number of selectable instruction inputs (>=2).
REQ-003 Parameter AW, default $clog2(DEPTH), SHALL be the address width of all PC-related ports.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 ins_bus  in  DEPTH*WIDTH  SHALL carry instruction k in bits [k*WIDTH +: WIDTH].
REQ-007 start  in  1  SHALL request sequencing from IDLE or HALTED.
REQ-008 halt  in  1  SHALL request sequencing stop.
REQ-009 jump  in  1  SHALL load jump_addr into pc in RUN.
REQ-010 jump_addr  in  AW  SHALL be the jump target.
REQ-011 pc  out  AW  SHALL be the address selected in the current cycle.
REQ-012 ins  out  WIDTH  SHALL be the registered selected instruction.
REQ-013 ins_pc  out  AW  SHALL be the address ins was fetched from.
REQ-014 ins_valid  out  1  SHALL mark ins as a new fetch this cycle.
REQ-015 running  out  1  SHALL be high only in RUN.
REQ-016 wrap  out  1  SHALL pulse one cycle when pc wraps DEPTH-1 -> 0 by increment.
REQ-017 err  out  1  SHALL pulse one cycle on an out-of-range jump.

Function
REQ-018 FSM states SHALL be IDLE, RUN, HALTED.
REQ-019 IDLE: start -> RUN; pc held; ins_valid 0.
REQ-020 RUN, per cycle: ins <= ins_bus word[pc], ins_pc <= pc, ins_valid <= 1 (one-cycle fetch latency).
REQ-021 RUN pc update priority SHALL be halt > jump > increment.
REQ-022 halt in RUN -> HALTED; no fetch that cycle; pc, ins, ins_pc held; ins_valid <= 0.
REQ-023 jump with jump_addr < DEPTH -> pc <= jump_addr; fetch of current pc still occurs.
REQ-024 jump with jump_addr >= DEPTH -> pc <= 0, err pulses; fetch still occurs.
REQ-025 Increment: pc <= pc+1, with DEPTH-1 -> 0 and wrap pulse; a jump from DEPTH-1 SHALL NOT pulse wrap.
REQ-026 HALTED: start (halt low) -> RUN, resuming from held pc; start and halt both high -> stay HALTED.
REQ-027 IDLE: start and halt both high -> stay IDLE.
REQ-028 jump in IDLE or HALTED SHALL be ignored.
REQ-029 ins and ins_pc SHALL hold last values outside RUN.

Reset
REQ-030 reset SHALL force IDLE, pc=0, ins=0, ins_pc=0, ins_valid=0, wrap=0, err=0, running=0.
REQ-031 reset SHALL override all inputs, including mid-RUN.
REQ-032 After reset deasserts, the first fetch SHALL be address 0, one cycle after start is sampled.

Structure
REQ-033 A shared package SHALL hold the state enum and the default WIDTH and DEPTH constants.
REQ-034 Word selection SHALL use one sub-module mux_n_1: a combinational parametrised WIDTH-bit DEPTH:1 mux on a binary select.
REQ-035 Out-of-range mux select SHALL yield all-zero output.

Verification
REQ-036 Defaults, ins_bus word k = k+1, start one cycle: ins = 1,2,...,16,1 on consecutive cycles; ins_pc = 0..15,0; wrap pulses once per lap.
REQ-037 RUN at pc=5, jump with jump_addr=12: next fetches ins_pc = 5,12,13; no wrap, no err.
REQ-038 DEPTH=10, jump_addr=11: err pulses once; next fetch ins_pc=0.
REQ-039 halt at pc=7, hold 3 cycles, then start: ins_valid=0 while halted; ins holds; first fetch after resume is ins_pc=7.
REQ-040 reset mid-RUN at pc=9: next cycle all outputs at reset values; state IDLE; start refetches ins_pc=0.
REQ-041 halt, jump and start asserted together in RUN: HALTED, pc unchanged, err=0.
